frame_buffer: RTL and testbench

Frame store that serves the image-read side of the convolution datapath. A raster pixel stream loads it once per frame; it then answers the convolver's x/y read requests (`x_addr_img`, `y_addr_img`, `ren_img` to `rdat_img`) with fixed one-cycle latency. It also resolves out-of-frame addresses produced at kernel borders. It sits between the image source (camera/DMA loader) and the Gaussian convolution block.

---
 rtl/frame_buffer_pkg.sv | 24 ++
 rtl/fb_ram.sv | 27 ++
 rtl/frame_buffer.sv | 115 +++++++++++
 tb/tb_frame_buffer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_buffer_pkg.sv
// Shared dimensions, FSM state type and linear-address helper for the frame buffer.
// Build option: define FRAME_BUFFER_CLAMP_EN for replicate padding, otherwise zero padding.
package frame_buffer_pkg;

  localparam int unsigned X_MAX       = 200;
  localparam int unsigned Y_MAX       = 200;
  localparam int unsigned PIXEL_DEPTH = 8;
  localparam int unsigned XW          = $clog2(X_MAX);
  localparam int unsigned YW          = $clog2(Y_MAX);
  localparam int unsigned DEPTH       = X_MAX * Y_MAX;
  localparam int unsigned ADDR_W      = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } fb_state_e;

  // Row-major address with the full X_MAX stride.
  function automatic logic [ADDR_W-1:0] lin_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return ADDR_W'(32'(y) * X_MAX + 32'(x));
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Contents are not reset.
module fb_ram #(
  parameter int unsigned DEPTH = 40000,
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_buffer.sv
// Frame store: raster load, then 1-cycle-latency x/y reads with border handling.
// Build option FRAME_BUFFER_CLAMP_EN: replicate padding; undefined: zero padding.
module frame_buffer
  import frame_buffer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_start,
  input  logic [XW-1:0]          max_x,
  input  logic [YW-1:0]          max_y,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PIXEL_DEPTH-1:0] in_pixel,
  output logic                   frame_ready,
  output logic                   load_done,
  input  logic signed [XW:0]     x_addr_img,
  input  logic signed [YW:0]     y_addr_img,
  input  logic                   ren_img,
  output logic [PIXEL_DEPTH-1:0] rdat_img,
  output logic                   rd_err
);

  fb_state_e              state_q;
  logic [XW-1:0]          wr_x_q, wr_x_d, max_x_q, rd_x;
  logic [YW-1:0]          wr_y_q, wr_y_d, max_y_q, rd_y;
  logic                   frame_ready_q, load_done_q, rd_err_q, zero_q;
  logic                   accept, last_px, is_ready, ram_re;
  logic                   x_lo, x_hi, y_lo, y_hi;
  logic [PIXEL_DEPTH-1:0] ram_rdata;

  assign in_ready = (state_q == LOAD) && !load_start;
  assign accept   = in_ready && in_valid;
  assign last_px  = (wr_x_q == max_x_q) && (wr_y_q == max_y_q);
  assign wr_x_d   = (wr_x_q == max_x_q) ? '0 : XW'(wr_x_q + 1'b1);
  assign wr_y_d   = (wr_x_q == max_x_q) ? YW'(wr_y_q + 1'b1) : wr_y_q;
  assign is_ready = (state_q == READY);

  // Load FSM and raster write counters; load_start overrides any same-cycle accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_x_q        <= '0;
      wr_y_q        <= '0;
      max_x_q       <= '0;
      max_y_q       <= '0;
      frame_ready_q <= 1'b0;
      load_done_q   <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      if (load_start) begin
        state_q       <= LOAD;
        max_x_q       <= max_x;
        max_y_q       <= max_y;
        wr_x_q        <= '0;
        wr_y_q        <= '0;
        frame_ready_q <= 1'b0;
      end else if (accept) begin
        wr_x_q <= wr_x_d;
        wr_y_q <= wr_y_d;
        if (last_px) begin
          state_q       <= READY;
          frame_ready_q <= 1'b1;
          load_done_q   <= 1'b1;
        end
      end
    end
  end

  // Signed range check against the latched frame size.
  assign x_lo = x_addr_img[XW];
  assign y_lo = y_addr_img[YW];
  assign x_hi = x_addr_img > $signed({1'b0, max_x_q});
  assign y_hi = y_addr_img > $signed({1'b0, max_y_q});

`ifdef FRAME_BUFFER_CLAMP_EN
  assign rd_x   = x_lo ? '0 : (x_hi ? max_x_q : x_addr_img[XW-1:0]);
  assign rd_y   = y_lo ? '0 : (y_hi ? max_y_q : y_addr_img[YW-1:0]);
  assign ram_re = ren_img && is_ready;
`else
  assign rd_x   = x_addr_img[XW-1:0];
  assign rd_y   = y_addr_img[YW-1:0];
  assign ram_re = ren_img && is_ready && !(x_lo || x_hi || y_lo || y_hi);
`endif

  // Any enabled read that skips memory returns zero; idle cycles hold the last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_err_q <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      rd_err_q <= ren_img && !is_ready;
      if (ren_img) zero_q <= !ram_re;
    end
  end

  fb_ram #(
    .DEPTH (DEPTH),
    .AW    (ADDR_W),
    .DW    (PIXEL_DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i (lin_addr(wr_x_q, wr_y_q)),
    .wdata_i (in_pixel),
    .re_i    (ram_re),
    .raddr_i (lin_addr(rd_x, rd_y)),
    .rdata_o (ram_rdata)
  );

  assign rdat_img    = zero_q ? '0 : ram_rdata;
  assign rd_err      = rd_err_q;
  assign frame_ready = frame_ready_q;
  assign load_done   = load_done_q;

endmodule

// File: tb/tb_frame_buffer.sv
// Directed bench for frame_buffer: frame-level reference model checked every cycle plus literal pins.
module tb_frame_buffer;
  import frame_buffer_pkg::*;

`ifdef FRAME_BUFFER_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   load_start = 1'b0;
  logic [XW-1:0]          max_x = '0;
  logic [YW-1:0]          max_y = '0;
  logic                   in_valid = 1'b0;
  logic [PIXEL_DEPTH-1:0] in_pixel = '0;
  logic signed [XW:0]     x_addr_img = '0;
  logic signed [YW:0]     y_addr_img = '0;
  logic                   ren_img = 1'b0;
  logic                   in_ready, frame_ready, load_done, rd_err;
  logic [PIXEL_DEPTH-1:0] rdat_img;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  frame_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .max_x       (max_x),
    .max_y       (max_y),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pixel    (in_pixel),
    .frame_ready (frame_ready),
    .load_done   (load_done),
    .x_addr_img  (x_addr_img),
    .y_addr_img  (y_addr_img),
    .ren_img     (ren_img),
    .rdat_img    (rdat_img),
    .rd_err      (rd_err)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a compact (mx+1)*(my+1) image indexed by pixel order.
  bit m_on = 0, m_loading = 0, m_ready = 0;
  int m_mx = 0, m_my = 0, m_cnt = 0;
  int img [int];
  int e_rdat = 0;
  bit e_rd_err = 0, e_load_done = 0, e_frame_ready = 0;

  function automatic int model_read(input int x, input int y);
    if (CLAMP) begin
      if (x < 0) x = 0;
      if (x > m_mx) x = m_mx;
      if (y < 0) y = 0;
      if (y > m_my) y = m_my;
    end else if (x < 0 || x > m_mx || y < 0 || y > m_my) begin
      return 0;
    end
    return img[y * (m_mx + 1) + x];
  endfunction

  always @(posedge clk) begin
    int xi, yi;
    xi = x_addr_img;
    yi = y_addr_img;
    e_load_done = 0;
    e_rd_err    = 0;
    if (rst) begin
      m_on = 1; m_loading = 0; m_ready = 0; m_cnt = 0;
      e_rdat = 0; e_frame_ready = 0;
    end else begin
      if (ren_img) begin
        if (!m_ready) begin
          e_rdat = 0;
          e_rd_err = 1;
        end else begin
          e_rdat = model_read(xi, yi);
        end
      end
      if (load_start) begin
        m_loading = 1; m_ready = 0; m_cnt = 0;
        m_mx = int'(max_x); m_my = int'(max_y);
        e_frame_ready = 0;
      end else if (m_loading && in_valid) begin
        img[m_cnt] = int'(in_pixel);
        m_cnt++;
        if (m_cnt == (m_mx + 1) * (m_my + 1)) begin
          m_loading = 0; m_ready = 1;
          e_load_done = 1; e_frame_ready = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      check("cmp_rdat_img", int'(rdat_img), e_rdat);
      check("cmp_rd_err", int'(rd_err), int'(e_rd_err));
      check("cmp_load_done", int'(load_done), int'(e_load_done));
      check("cmp_frame_ready", int'(frame_ready), int'(e_frame_ready));
      check("cmp_in_ready", int'(in_ready), int'(m_loading && !load_start));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int x, input int y);
    ren_img    = 1'b1;
    x_addr_img = (XW+1)'(x);
    y_addr_img = (YW+1)'(y);
    cyc();
    ren_img = 1'b0;
  endtask

  task automatic stream(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_pixel = PIXEL_DEPTH'(base + i);
      cyc();
    end
    in_valid = 1'b0;
  endtask

  task automatic start(input int mx, input int my);
    load_start = 1'b1;
    max_x = XW'(mx);
    max_y = YW'(my);
    cyc();
    load_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    check("rst_frame_ready", int'(frame_ready), 0);
    check("rst_rdat", int'(rdat_img), 0);
    check("rst_in_ready", int'(in_ready), 0);

    // Read before any load
    rd(0, 0);
    check("preload_rd_err", int'(rd_err), 1);
    check("preload_rdat", int'(rdat_img), 0);
    cyc();
    check("rd_err_one_cycle", int'(rd_err), 0);

    // 4x3 frame with values 1..12
    start(3, 2);
    stream(12, 1);
    check("load_done", int'(load_done), 1);
    check("frame_ready", int'(frame_ready), 1);
    cyc();
    check("load_done_pulse", int'(load_done), 0);

    rd(2, 1);
    check("rd_2_1", int'(rdat_img), 7);
    rd(0, 0);
    check("rd_0_0", int'(rdat_img), 1);
    rd(3, 2);
    check("rd_3_2", int'(rdat_img), 12);
    cyc();
    check("rd_hold", int'(rdat_img), 12);

    // Border reads
    rd(-1, 0);
    check("oor_xneg", int'(rdat_img), CLAMP ? 1 : 0);
    check("oor_xneg_rd_err", int'(rd_err), 0);
    rd(4, 2);
    check("oor_xhi", int'(rdat_img), CLAMP ? 12 : 0);
    check("oor_xhi_rd_err", int'(rd_err), 0);
    rd(1, -1);
    rd(2, 3);
    rd(-256, -256);
    rd(255, 255);
    rd(1, 1);
    check("rd_1_1", int'(rdat_img), 6);

    // load_start during a read: that read still completes
    ren_img = 1'b1; x_addr_img = 9'sd1; y_addr_img = 9'sd0;
    load_start = 1'b1; max_x = XW'(3); max_y = YW'(2);
    cyc();
    ren_img = 1'b0; load_start = 1'b0;
    check("rd_at_restart", int'(rdat_img), 2);
    check("rd_at_restart_err", int'(rd_err), 0);
    check("ready_drop", int'(frame_ready), 0);
    rd(0, 0);
    check("rd_during_load_err", int'(rd_err), 1);

    // Restart after 5 accepts; the colliding pixel is dropped
    stream(5, 100);
    in_valid = 1'b1; in_pixel = 8'd99; load_start = 1'b1;
    #1;
    check("in_ready_restart", int'(in_ready), 0);
    cyc();
    load_start = 1'b0; in_valid = 1'b0;
    check("restart_not_ready", int'(frame_ready), 0);
    stream(12, 50);
    check("reload_done", int'(load_done), 1);
    rd(0, 0);
    check("reload_0_0", int'(rdat_img), 50);
    rd(3, 2);
    check("reload_3_2", int'(rdat_img), 61);
    rd(1, 1);

    // Reset mid-load
    start(3, 2);
    stream(6, 200);
    rst = 1'b1; in_valid = 1'b1; in_pixel = 8'd77;
    cyc();
    check("midrst_in_ready", int'(in_ready), 0);
    check("midrst_frame_ready", int'(frame_ready), 0);
    check("midrst_rdat", int'(rdat_img), 0);
    rst = 1'b0; in_valid = 1'b0;
    rd(0, 0);
    check("post_rst_rd_err", int'(rd_err), 1);
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
